// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_pkg
// Brief    : RV32I opcode/funct constants, f3OpInt and the ALU operand bundle.
// Revision : 1.0
// ============================================================================
package alu_issue_pkg;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;

    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SLL  = 3'd1,
        SLT  = 3'd2,
        SLTU = 3'd3,
        XOR  = 3'd4,
        SR   = 3'd5,
        OR   = 3'd6,
        AND  = 3'd7
    } f3OpInt;

    typedef struct packed {
        logic        op;
        logic        op_imm;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] a;
        logic [31:0] b;
    } alu_bundle_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_decode
// Brief    : Combinational RV32I decode into the ALU operand bundle.
// Revision : 1.0
// ============================================================================
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output alu_bundle_t     o_bundle,
    output logic [4:0]      o_rd,
    output logic            o_legal,
    output logic            o_uses_rs2,
    output logic            o_rd_we
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_is_shift;

    assign w_opcode   = i_instr[6:0];
    assign w_f3       = i_instr[14:12];
    assign w_f7       = i_instr[31:25];
    assign o_rd       = i_instr[11:7];
    assign w_is_shift = (w_f3 == SLL) || (w_f3 == SR);

    always_comb begin
        o_bundle   = '0;
        o_legal    = 1'b0;
        o_uses_rs2 = 1'b0;
        case (w_opcode)
            c_opc_op: begin
                o_uses_rs2      = 1'b1;
                o_bundle.op     = 1'b1;
                o_bundle.funct3 = w_f3;
                o_bundle.funct7 = w_f7;
                o_bundle.a      = i_rs1_data;
                o_bundle.b      = w_is_shift ? {27'd0, i_rs2_data[4:0]} : i_rs2_data;
                o_legal         = (w_f7 == c_f7_base) ||
                                  ((w_f7 == c_f7_alt) && ((w_f3 == ADD) || (w_f3 == SR)));
            end
            c_opc_op_imm: begin
                o_bundle.op_imm = 1'b1;
                o_bundle.funct3 = w_f3;
                o_bundle.a      = i_rs1_data;
                if (w_is_shift) begin
                    // Shift immediates carry the SRA/SRL selector in the funct7 slot
                    o_bundle.funct7 = w_f7;
                    o_bundle.b      = {27'd0, i_instr[24:20]};
                    o_legal         = (w_f7 == c_f7_base) || ((w_f3 == SR) && (w_f7 == c_f7_alt));
                end else begin
                    o_bundle.b = {{20{i_instr[31]}}, i_instr[31:20]};
                    o_legal    = 1'b1;
                end
            end
            c_opc_lui, c_opc_auipc: begin
                o_bundle.op_imm = 1'b1;
                o_bundle.funct3 = ADD;
                o_bundle.a      = (w_opcode == c_opc_auipc) ? i_pc : '0;
                o_bundle.b      = {i_instr[31:12], 12'd0};
                o_legal         = 1'b1;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

    assign o_rd_we = o_legal && (o_rd != 5'd0);

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Brief    : RV32I decode/issue stage with pending-register scoreboard.
//            Optional ALU_ISSUE_ILLEGAL_EN forwards illegal beats with out_illegal.
// Revision : 1.0
// ============================================================================
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            op,
    output logic            op_imm,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_pc
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    alu_bundle_t     w_bundle;
    logic [4:0]      w_rd;
    logic            w_legal;
    logic            w_uses_rs2;
    logic            w_rd_we;
    logic            w_stall;
    logic            w_accept;
    logic            w_load;
    logic            w_beat;
    logic [31:0]     w_pending_nxt;

    alu_bundle_t     r_bundle;
    logic [4:0]      r_rd;
    logic            r_rd_we;
    logic [XLEN-1:0] r_pc;
    logic            r_out_valid;
    logic [31:0]     r_pending;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    alu_issue_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_instr    (in_instr),
        .i_pc       (in_pc),
        .i_rs1_data (rs1_data),
        .i_rs2_data (rs2_data),
        .o_bundle   (w_bundle),
        .o_rd       (w_rd),
        .o_legal    (w_legal),
        .o_uses_rs2 (w_uses_rs2),
        .o_rd_we    (w_rd_we)
    );

    // Registered bitmap only: a writeback in this cycle unblocks next cycle
    assign w_stall  = r_pending[rs1_addr] || (w_uses_rs2 && r_pending[rs2_addr]) || r_pending[w_rd];
    assign in_ready = !w_stall && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef ALU_ISSUE_ILLEGAL_EN
    assign w_beat = 1'b1;
    assign w_load = w_accept;
`else
    assign w_beat = w_legal;
    assign w_load = w_accept && w_legal;
`endif

    always_comb begin
        w_pending_nxt = r_pending;
        if (wb_valid) begin
            w_pending_nxt[wb_rd] = 1'b0;
        end
        if (w_accept && w_rd_we) begin
            w_pending_nxt[w_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_pending   <= '0;
            r_bundle    <= '0;
            r_rd        <= '0;
            r_rd_we     <= 1'b0;
            r_pc        <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_load) begin
                r_bundle <= w_bundle;
                r_rd     <= w_rd;
                r_rd_we  <= w_rd_we;
                r_pc     <= in_pc;
            end
            if (w_accept) begin
                r_out_valid <= w_beat;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_load) begin
            r_illegal <= !w_legal;
        end
    end

    assign out_illegal = r_illegal;
`endif

    assign out_valid = r_out_valid;
    assign op        = r_bundle.op;
    assign op_imm    = r_bundle.op_imm;
    assign funct3    = r_bundle.funct3;
    assign funct7    = r_bundle.funct7;
    assign a         = r_bundle.a;
    assign b         = r_bundle.b;
    assign out_rd    = r_rd;
    assign out_rd_we = r_rd_we;
    assign out_pc    = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Brief    : Randomised scoreboard bench for alu_issue against an ISA-level model.
// Revision : 1.0
// ============================================================================
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        out_valid, out_ready;
    logic        op, op_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] a, b, out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op        (op),
        .op_imm    (op_imm),
        .funct3    (funct3),
        .funct7    (funct7),
        .a         (a),
        .b         (b),
        .out_rd    (out_rd),
        .out_rd_we (out_rd_we),
        .out_pc    (out_pc)
`ifdef ALU_ISSUE_ILLEGAL_EN
        ,
        .out_illegal (out_illegal)
`endif
    );

`ifndef ALU_ISSUE_ILLEGAL_EN
    assign out_illegal = 1'b0;
`endif

    typedef struct {
        logic        beat;
        logic        illegal;
        logic        op;
        logic        op_imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rd_we;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_pend;
    logic        m_ov;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // ISA-level meaning of one instruction
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic legal;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        legal = 1'b0;
        e.op = 0; e.op_imm = 0; e.f3 = 0; e.f7 = 0; e.a = 0; e.b = 0;
        case (ins[6:0])
            7'h33: begin
                e.op = 1; e.f3 = f3; e.f7 = f7; e.a = r1;
                e.b = (f3 == 1 || f3 == 5) ? r2 % 32 : r2;
                legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            end
            7'h13: begin
                e.op_imm = 1; e.f3 = f3; e.a = r1;
                if (f3 == 1 || f3 == 5) begin
                    e.f7 = f7; e.b = 32'(ins[24:20]);
                    legal = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
                end else begin
                    e.b = $signed(ins) >>> 20;
                    legal = 1;
                end
            end
            7'h37, 7'h17: begin
                e.op_imm = 1; e.f3 = 0;
                e.a = (ins[6:0] == 7'h17) ? pc : 32'd0;
                e.b = ins & 32'hFFFF_F000;
                legal = 1;
            end
            default: legal = 0;
        endcase
        e.illegal = !legal;
        e.rd      = ins[11:7];
        e.rd_we   = legal && (e.rd != 0);
        e.pc      = pc;
`ifdef ALU_ISSUE_ILLEGAL_EN
        e.beat = 1'b1;
`else
        e.beat = legal;
`endif
        return e;
    endfunction

    function automatic logic model_stall(input logic [31:0] ins);
        return m_pend[ins[19:15]] || (ins[6:0] == 7'h33 && m_pend[ins[24:20]]) || m_pend[ins[11:7]];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [4:0]  rd, rs1, rs2;
        logic [6:0]  f7, opc;
        int k, s;
        w   = $urandom;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        s   = $urandom_range(0, 5);
        f7  = (s < 3) ? 7'h00 : (s < 5) ? 7'h20 : 7'($urandom);
        opc = 7'($urandom);
        k   = $urandom_range(0, 9);
        if (k < 4)      return {f7, rs2, rs1, w[14:12], rd, 7'h33};
        else if (k < 7) return (w[13:12] == 2'b01) ? {f7, w[24:20], rs1, w[14:12], rd, 7'h13}
                                                   : {w[31:20], rs1, w[14:12], rd, 7'h13};
        else if (k == 7) return {w[31:12], rd, 7'h37};
        else if (k == 8) return {w[31:12], rd, 7'h17};
        else             return {w[31:12], rd, opc};
    endfunction

    // Monitor: compares every presented beat against the scoreboard head
    exp_t me;
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (out_valid && q.size() > 0) begin
                me = q[0];
                check("out_rd", 32'(out_rd), 32'(me.rd));
                check("out_rd_we", 32'(out_rd_we), 32'(me.rd_we));
                check("out_pc", out_pc, me.pc);
`ifdef ALU_ISSUE_ILLEGAL_EN
                check("out_illegal", 32'(out_illegal), 32'(me.illegal));
`endif
                if (!me.illegal) begin
                    check("op", 32'(op), 32'(me.op));
                    check("op_imm", 32'(op_imm), 32'(me.op_imm));
                    check("funct3", 32'(funct3), 32'(me.f3));
                    check("funct7", 32'(funct7), 32'(me.f7));
                    check("a", a, me.a);
                    check("b", b, me.b);
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // One cycle: drive at posedge+1, check in_ready, then advance the model at the edge
    task automatic run_cycle(input logic v, input logic [31:0] ins, input logic ordy,
                             input logic [31:0] r1, output logic acc);
        logic exp_rdy;
        exp_t e;
        int idx;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        rs1_data  = r1;
        rs2_data  = $urandom;
        out_ready = ordy;
        wb_valid  = 1'b0;
        wb_rd     = 5'($urandom);
        if (m_pend != 0 && $urandom_range(0, 2) == 0) begin
            idx = $urandom_range(1, 31);
            while (!m_pend[idx]) idx = (idx % 31) + 1;
            wb_valid = 1'b1;
            wb_rd    = 5'(idx);
        end
        exp_rdy = !model_stall(ins) && (!m_ov || ordy);
        #2;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("rs_addr", {22'd0, rs1_addr, rs2_addr}, {22'd0, ins[19:15], ins[24:20]});
        @(posedge clk);
        acc = v && exp_rdy;
        e = model(ins, in_pc, rs1_data, rs2_data);
        if (wb_valid) m_pend[wb_rd] = 1'b0;
        if (acc && e.rd_we) m_pend[e.rd] = 1'b1;
        if (acc) begin
            m_ov = e.beat;
            if (e.beat) q.push_back(e);
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic ordy_rand);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 300) begin
            run_cycle(1'b1, ins, ordy_rand ? ($urandom_range(0, 3) != 0) : 1'b1, r1, acc);
            n++;
        end
        if (!acc) begin
            errors++;
            $display("FAIL issue_timeout instr=%h", ins);
        end
    endtask

    initial begin
        logic acc;
        logic [31:0] cur;
        logic [31:0] dir[5];
        logic [31:0] r1v;
        int n;
        dir[0] = 32'h0050_0093; // ADDI x1,x0,5
        dir[1] = 32'h4020_81B3; // SUB x3,x1,x2
        dir[2] = 32'h4032_5293; // SRAI x5,x4,3
        dir[3] = 32'h1234_53B7; // LUI x7,0x12345
        dir[4] = 32'h0000_007F; // illegal opcode
        m_pend = '0; m_ov = 1'b0;
        rst_n = 1'b0; in_valid = 0; in_instr = 0; in_pc = 0;
        rs1_data = 0; rs2_data = 0; wb_valid = 0; wb_rd = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_bundle", {a ^ b, 21'd0, op, op_imm, funct3, funct7}, 0);
        check("rst_rd", {26'd0, out_rd, out_rd_we}, 0);
        check("rst_illegal", 32'(out_illegal), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            r1v = (i == 2) ? 32'h8000_0000 : $urandom;
            issue(dir[i], r1v, i == 3);
        end

        cur = rand_instr();
        for (int i = 0; i < 1500; i++) begin
            run_cycle($urandom_range(0, 3) != 0, cur, $urandom_range(0, 3) != 0, $urandom, acc);
            if (acc) cur = rand_instr();
        end

        // Drain, then reset while a beat for x1 is held and x1 is pending
        n = 0;
        while ((q.size() > 0 || m_pend != 0) && n < 200) begin
            run_cycle(1'b0, 32'h0, 1'b1, $urandom, acc);
            n++;
        end
        check("drain_idle", {31'd0, q.size() > 0}, 0);
        issue(32'h0050_0093, 32'h0, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        wb_valid  = 1'b0;
        @(negedge clk);
        check("hold_before_reset", 32'(out_valid), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset_out_valid", 32'(out_valid), 0);
        q.delete();
        m_pend = '0;
        m_ov   = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_instr = 32'h0000_8133; // ADD x2,x1,x0
        #1 check("x1_free_after_reset", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        issue(32'h0000_8133, $urandom, 1'b0);
        n = 0;
        while (q.size() > 0 && n < 20) begin
            run_cycle(1'b0, 32'h0, 1'b1, $urandom, acc);
            n++;
        end
        check("final_queue_empty", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
